// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: recode ops,
// FSM states and the derived iteration count.
package mult_pkg;

    typedef enum logic [2:0] {
        ZERO,
        PA,
        P2A,
        NA,
        N2A
    } booth_op_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // Operands are widened by two bits, so WIDTH/2+1 radix-4 digits cover them.
    function automatic int booth_steps(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window onto a signed
// partial product of 0, +/-A or +/-2A.
module booth_pp_sel
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]              win,
    input  logic [WIDTH+1:0]        mcand,
    output logic signed [WIDTH+2:0] pp
);

    booth_op_e              op;
    logic signed [WIDTH+2:0] a1;
    logic signed [WIDTH+2:0] a2;

    assign a1 = {mcand[WIDTH+1], mcand};
    assign a2 = {mcand, 1'b0};

    always_comb begin
        op = ZERO;
        case (win)
            3'b001, 3'b010: op = PA;
            3'b011:         op = P2A;
            3'b100:         op = N2A;
            3'b101, 3'b110: op = NA;
            default:        op = ZERO;
        endcase
    end

    // The multiplicand is only ever a widened WIDTH-bit value, so 2A and its
    // negation never overflow WIDTH+3 bits.
    always_comb begin
        pp = '0;
        case (op)
            PA:      pp = a1;
            P2A:     pp = a2;
            NA:      pp = -a1;
            N2A:     pp = -a2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/mult_booth_param.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, signed or
// unsigned operands, result held in y with a one-cycle done pulse.
module mult_booth_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEPS = WIDTH / 2 + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy,
    output logic                 done
);

    localparam int EW = WIDTH + 2;         // extended operand width
    localparam int HW = WIDTH + 4;         // upper accumulator, with headroom for the add
    localparam int AW = HW + EW + 1;       // {upper, multiplier, b[-1]}
    localparam int CW = $clog2(STEPS + 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("mult_booth_param: WIDTH must be even and >= 4");
    end
    if (STEPS != booth_steps(WIDTH)) begin : g_bad_steps
        $error("mult_booth_param: STEPS is derived from WIDTH and must not be overridden");
    end

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [EW-1:0]         mcand_q, mcand_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [2*WIDTH-1:0]    y_q, y_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic signed [WIDTH+2:0] pp;
    logic signed [HW-1:0]    hi_sum;
    logic signed [AW-1:0]    step_acc;
    logic [EW-1:0]           a_ext;
    logic [EW-1:0]           b_ext;

    booth_pp_sel #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .win   (acc_q[2:0]),
        .mcand (mcand_q),
        .pp    (pp)
    );

    assign a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
    assign b_ext = {{2{is_signed & b[WIDTH-1]}}, b};

    // The multiplier rides in the low half of the accumulator and is consumed
    // two bits per step as the product shifts in above it.
    assign hi_sum   = $signed(acc_q[AW-1:EW+1]) + $signed({pp[WIDTH+2], pp});
    assign step_acc = $signed({hi_sum, acc_q[EW:0]}) >>> 2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (init) begin
                    state_d = RUN;
                    mcand_d = a_ext;
                    acc_d   = {{HW{1'b0}}, b_ext, 1'b0};
                    cnt_d   = CW'(STEPS);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d  = step_acc;
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    y_d     = step_acc[2*WIDTH:1];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_booth_param.sv
// Directed and randomized checks of the Booth multiplier at WIDTH=8 and WIDTH=16.
module tb_mult_booth_param;

    logic        clk;
    logic        reset;
    logic        init8;
    logic [7:0]  a8, b8;
    logic        s8;
    logic [15:0] y8;
    logic        busy8, done8;

    logic                  init16;
    logic [3:0][15:0]      a16, b16;
    logic [3:0]            s16;
    logic [3:0][31:0]      y16;
    logic [3:0]            busy16, done16;
    logic [3:0][31:0]      exp16;

    int          n_tests;
    int          n_fail;
    logic [15:0] last_y;

    mult_booth_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .init(init8), .a(a8), .b(b8),
        .is_signed(s8), .y(y8), .busy(busy8), .done(done8)
    );

    for (genvar g = 0; g < 4; g++) begin : g_w16
        mult_booth_param #(.WIDTH(16)) u_dut16 (
            .clk(clk), .reset(reset), .init(init16), .a(a16[g]), .b(b16[g]),
            .is_signed(s16[g]), .y(y16[g]), .busy(busy16[g]), .done(done16[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] z, input logic s);
        int sx, sz;
        if (s) begin
            sx = int'($signed(x));
            sz = int'($signed(z));
        end else begin
            sx = int'({16'h0, x});
            sz = int'({16'h0, z});
        end
        return 32'(sx * sz);
    endfunction

    // One full WIDTH=8 operation: init in cycle 0, busy in 1..5, done in 6.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input string tag);
        chk($sformatf("%s_pre", tag), {30'd0, busy8, done8}, 32'd0);
        a8 = a; b8 = b; s8 = s; init8 = 1'b1;
        tick();
        init8 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("%s_c%0d", tag, c), {14'd0, busy8, done8, y8}, {14'd0, 2'b10, last_y});
            tick();
        end
        chk($sformatf("%s_done", tag), {30'd0, busy8, done8}, 32'd1);
        chk($sformatf("%s_y", tag), {16'd0, y8}, {16'd0, exp});
        last_y = exp;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        last_y  = '0;
        reset = 1'b1; init8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
        init16 = 1'b0; a16 = '0; b16 = '0; s16 = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_y", {16'd0, y8}, 32'd0);
        init8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        tick();
        chk("rst_prio_busy", {31'd0, busy8}, 32'd0);
        init8 = 1'b0;
        reset = 1'b0;

        run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ffxff");
        run8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_ffxff");
        run8(8'h80, 8'h80, 1'b1, 16'h4000, "s_80x80");
        run8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_80x7f");
        run8(8'h80, 8'h7F, 1'b0, 16'h3F80, "u_80x7f");
        run8(8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_7fx7f");
        run8(8'h00, 8'hAB, 1'b0, 16'h0000, "u_0xab");
        run8(8'h01, 8'hFF, 1'b1, 16'hFFFF, "s_1xm1");
        run8(8'h01, 8'hFF, 1'b0, 16'h00FF, "u_1xff");
        run8(8'hFF, 8'h02, 1'b0, 16'h01FE, "u_ffx2");
        run8(8'hFF, 8'h02, 1'b1, 16'hFFFE, "s_m1x2");

        // Ghost init mid-run is ignored; the next op starts in the done cycle.
        a8 = 8'h07; b8 = 8'hFA; s8 = 1'b1; init8 = 1'b1;
        tick();
        init8 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                init8 = 1'b1; a8 = 8'h11; b8 = 8'h22; s8 = 1'b0;
            end
            chk($sformatf("b2b1_c%0d", c), {14'd0, busy8, done8, y8}, {14'd0, 2'b10, last_y});
            tick();
            init8 = 1'b0;
        end
        chk("b2b1_done", {30'd0, busy8, done8}, 32'd1);
        chk("b2b1_y", {16'd0, y8}, 32'h0000FFD6);
        last_y = 16'hFFD6;
        a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; init8 = 1'b1;
        tick();
        init8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("b2b2_c%0d", c), {14'd0, busy8, done8, y8}, {14'd0, 2'b10, last_y});
            tick();
        end
        chk("b2b2_done", {30'd0, busy8, done8}, 32'd1);
        chk("b2b2_y", {16'd0, y8}, 32'h000003A8);
        last_y = 16'h03A8;
        tick();

        // Reset in cycle 3 aborts the run without a done pulse.
        a8 = 8'h55; b8 = 8'h03; s8 = 1'b1; init8 = 1'b1;
        tick();
        init8 = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            chk($sformatf("abort_c%0d", c), {14'd0, busy8, done8, y8}, {14'd0, 2'b10, last_y});
            tick();
        end
        reset = 1'b1;
        tick();
        chk("abort_state", {14'd0, busy8, done8, y8}, 32'd0);
        reset = 1'b0;
        last_y = '0;
        run8(8'h0A, 8'h0B, 1'b0, 16'h006E, "post_rst");

        // WIDTH=16: 4 lanes x 2500 back-to-back ops, done always in cycle 10.
        for (int k = 0; k < 2500; k++) begin
            for (int j = 0; j < 4; j++) begin
                a16[j] = 16'($urandom);
                b16[j] = 16'($urandom);
                s16[j] = 1'($urandom_range(0, 1));
                if (k == 0 && j == 0) begin
                    a16[j] = 16'h8000; b16[j] = 16'h8000; s16[j] = 1'b1;
                end
                if (k == 0 && j == 1) begin
                    a16[j] = 16'hFFFF; b16[j] = 16'hFFFF; s16[j] = 1'b0;
                end
                exp16[j] = ref16(a16[j], b16[j], s16[j]);
            end
            init16 = 1'b1;
            tick();
            init16 = 1'b0;
            repeat (8) tick();
            for (int j = 0; j < 4; j++)
                chk($sformatf("w16_c9_l%0d_k%0d", j, k), {30'd0, busy16[j], done16[j]}, 32'd2);
            tick();
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("w16_done_l%0d_k%0d", j, k), {30'd0, busy16[j], done16[j]}, 32'd1);
                chk($sformatf("w16_y_l%0d_k%0d", j, k), y16[j], exp16[j]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_booth_param.md
MULT_BOOTH_PARAM -- requirements
Module: mult_booth_param

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, meaning the operand width; it SHALL be even and at least 4 (elaboration error otherwise).
REQ-002 The block SHALL take parameter STEPS, default WIDTH/2+1, meaning the radix-4 iteration count; it is derived and SHALL NOT be overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port init, input, 1 bit: start request.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier.
REQ-008 The block SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands.
REQ-009 The block SHALL have port y, output, 2*WIDTH bits: product.
REQ-010 The block SHALL have port busy, output, 1 bit: iteration in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse, y newly valid.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and RUN; IDLE->RUN on a clock edge with init=1 in IDLE; RUN->IDLE on the edge completing step STEPS.
REQ-013 On the accepting edge, the block SHALL latch a, b and is_signed, extend both operands to WIDTH+2 bits (sign-extend if is_signed=1, zero-extend otherwise), clear the accumulator, and load step counter = STEPS.
REQ-014 In RUN, each edge SHALL perform one radix-4 Booth step: recode 3 multiplier bits {b[2i+1], b[2i], b[2i-1]} (b[-1]=0) to 0, +A, +2A, -A or -2A, add to the upper accumulator, arithmetic-shift by 2, and decrement the counter.
REQ-015 busy SHALL be 1 for exactly STEPS cycles, starting the cycle after the accepting edge.
REQ-016 On the edge completing the last step, y SHALL load the low 2*WIDTH bits of the final product, and done SHALL be 1 for exactly the following cycle.
REQ-017 Latency SHALL be as follows: init sampled in cycle 0 gives done=1 in cycle STEPS+1 (cycle 6 for WIDTH=8).
REQ-018 y SHALL hold its value between completions; it SHALL NOT change during RUN.
REQ-019 init while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-020 init=1 in the done cycle (busy=0) SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-021 Changes to a, b or is_signed after acceptance SHALL NOT affect the running product.
REQ-022 The result SHALL be exact for all operand pairs in both modes; no overflow or saturation is possible.

Reset
REQ-023 With reset=1 at an edge, the FSM SHALL go to IDLE, and y=0, busy=0, done=0; the counter and accumulator SHALL be cleared.
REQ-024 Reset SHALL take priority over init; reset mid-RUN SHALL abort the operation, with no done pulse and y=0.
REQ-025 The first accepted init SHALL be the one sampled on the first edge after reset deasserts.

Structure
REQ-026 A shared package mult_pkg SHALL hold:
- the Booth-op enum (ZERO, PA, P2A, NA, N2A);
- the step-count function of WIDTH;
- the FSM state typedef.
REQ-027 Booth recoding and partial-product selection SHALL live in one sub-module, booth_pp_sel.
REQ-028 booth_pp_sel SHALL be combinational: 3-bit window plus WIDTH+2-bit multiplicand in, WIDTH+3-bit signed partial product out.
REQ-029 The top level SHALL contain:
- the FSM;
- the counter;
- the operand registers;
- the accumulator/shift datapath.

Verification
REQ-030 WIDTH=8, is_signed=1, a=0xFD (-3), b=0x05: the bench SHALL see y=0xFFF1 with done in cycle 6 and busy high for cycles 1-5.
REQ-031 WIDTH=8, is_signed=0, a=0xFF, b=0xFF: the bench SHALL see y=0xFE01; the same operands with is_signed=1 SHALL give y=0x0001.
REQ-032 WIDTH=8, signed corner cases: 0x80*0x80 SHALL give y=0x4000, and 0x80*0x7F SHALL give y=0xC080.
REQ-033 init re-pulsed in cycle 3 of a run, then re-asserted in the done cycle: the bench SHALL see the first result unaffected and the second operation start with no gap.
REQ-034 reset asserted in cycle 3 of a run: the bench SHALL see busy=0, y=0 and no done pulse, with the next init completing normally.
REQ-035 WIDTH=16, random signed and unsigned pairs (at least 10k) SHALL match a reference model, with done always in cycle 10.
